// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath
// selects and write enables. Memory accesses stall on mem_ready.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode              instr[6:0] from the instruction register
//   zero                ALU zero flag (branch decision)
//   mem_ready           memory completes the current access this cycle
//   PCWrite..PCSource   datapath enables and mux selects
//   ALUOp               00 add, 01 subtract, 10 Funct-decoded
//   instr_done          pulse in the final cycle of each instruction
//   illegal_op          pulse when an unsupported opcode is decoded
//   cycle_cnt/instr_cnt performance counters (only with MC_PERF_CNT_EN)
//
// Optional feature macro: MC_PERF_CNT_EN
module multicycle_control #(
    parameter int unsigned OPC_W   = 7,
    parameter int unsigned STATE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             PCSource,
    output logic             instr_done,
    output logic             illegal_op
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instr_cnt
`endif
);

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(7'b0110011);
    localparam logic [OPC_W-1:0] OP_IALU = OPC_W'(7'b0010011);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(7'b0000011);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(7'b0100011);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(7'b1100011);

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEM_ADDR = STATE_W'(2),
        MEM_RD   = STATE_W'(3),
        MEM_WR   = STATE_W'(4),
        MEM_WB   = STATE_W'(5),
        EXEC_R   = STATE_W'(6),
        EXEC_I   = STATE_W'(7),
        ALU_WB   = STATE_W'(8),
        BRANCH   = STATE_W'(9)
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALU_ADD;
        PCSource   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        // Outputs stay quiet during reset so an aborted instruction cannot
        // write anything or signal completion in the reset cycle.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_4;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = DECODE;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DECODE: begin
                    ALUSrcB = SRCB_IMM;
                    if (opcode == OP_LW || opcode == OP_SW) begin
                        state_d = MEM_ADDR;
                    end else if (opcode == OP_R) begin
                        state_d = EXEC_R;
                    end else if (opcode == OP_IALU) begin
                        state_d = EXEC_I;
                    end else if (opcode == OP_BEQ) begin
                        state_d = BRANCH;
                    end else begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = mem_ready ? MEM_WB : MEM_RD;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = MEM_WR;
                    end
                end
                MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REG;
                    ALUOp   = ALU_FUNCT;
                    state_d = ALU_WB;
                end
                EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_FUNCT;
                    state_d = ALU_WB;
                end
                ALU_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_REG;
                    ALUOp      = ALU_SUB;
                    PCSource   = 1'b1;
                    PCWrite    = zero;
                    instr_done = 1'b1;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. Each instruction is
// expanded into its expected per-cycle control-word sequence from the
// opcode, the chosen memory stall counts and the branch zero flag.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
    logic       ALUSrcA, PCSource, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOp;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control #(.OPC_W(7), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .instr_done(instr_done), .illegal_op(illegal_op)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Control word bit weights
    localparam logic [14:0] W_PCW  = 15'd1 << 14;
    localparam logic [14:0] W_IORD = 15'd1 << 13;
    localparam logic [14:0] W_MRD  = 15'd1 << 12;
    localparam logic [14:0] W_MWR  = 15'd1 << 11;
    localparam logic [14:0] W_IRW  = 15'd1 << 10;
    localparam logic [14:0] W_M2R  = 15'd1 << 9;
    localparam logic [14:0] W_RW   = 15'd1 << 8;
    localparam logic [14:0] W_SRCA = 15'd1 << 7;
    localparam logic [14:0] W_B4   = 15'd1 << 5;
    localparam logic [14:0] W_BIMM = 15'd2 << 5;
    localparam logic [14:0] W_SUB  = 15'd1 << 3;
    localparam logic [14:0] W_FN   = 15'd2 << 3;
    localparam logic [14:0] W_PCS  = 15'd1 << 2;
    localparam logic [14:0] W_DONE = 15'd1 << 1;
    localparam logic [14:0] W_ILL  = 15'd1;

    function automatic logic [14:0] ctl_word();
        return {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset     = 1'b1;
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            opcode    = 7'($urandom);
            #1;
            check("reset_quiet", 32'(ctl_word()), 32'd0);
        end
    endtask

    // zmode: 0/1 force zero to that value, 2 randomizes it every cycle.
    task automatic run_instr(input logic [6:0] op, input int fstall, input int mstall,
                             input int zmode, input string tag);
        logic [14:0] exp_q[$];
        bit          rdy_q[$];
        bit          br_q[$];
        logic [14:0] e;
        bit          is_mem;
        // Fetch: wait cycles, then the cycle that loads IR and PC.
        for (int i = 0; i < fstall; i++) begin
            exp_q.push_back(W_MRD | W_B4); rdy_q.push_back(0); br_q.push_back(0);
        end
        exp_q.push_back(W_MRD | W_B4 | W_IRW | W_PCW); rdy_q.push_back(1); br_q.push_back(0);
        is_mem = (op == 7'b0000011) || (op == 7'b0100011);
        if (is_mem || op == 7'b0110011 || op == 7'b0010011 || op == 7'b1100011) begin
            exp_q.push_back(W_BIMM); rdy_q.push_back(1'($urandom)); br_q.push_back(0);
        end else begin
            exp_q.push_back(W_BIMM | W_ILL | W_DONE); rdy_q.push_back(1'($urandom)); br_q.push_back(0);
        end
        if (is_mem) begin
            exp_q.push_back(W_SRCA | W_BIMM); rdy_q.push_back(1'($urandom)); br_q.push_back(0);
            e = (op == 7'b0000011) ? (W_MRD | W_IORD) : (W_MWR | W_IORD);
            for (int i = 0; i < mstall; i++) begin
                exp_q.push_back(e); rdy_q.push_back(0); br_q.push_back(0);
            end
            if (op == 7'b0000011) begin
                exp_q.push_back(e); rdy_q.push_back(1); br_q.push_back(0);
                exp_q.push_back(W_RW | W_M2R | W_DONE); rdy_q.push_back(1'($urandom)); br_q.push_back(0);
            end else begin
                exp_q.push_back(e | W_DONE); rdy_q.push_back(1); br_q.push_back(0);
            end
        end else if (op == 7'b0110011) begin
            exp_q.push_back(W_SRCA | W_FN); rdy_q.push_back(1'($urandom)); br_q.push_back(0);
            exp_q.push_back(W_RW | W_DONE); rdy_q.push_back(1'($urandom)); br_q.push_back(0);
        end else if (op == 7'b0010011) begin
            exp_q.push_back(W_SRCA | W_BIMM | W_FN); rdy_q.push_back(1'($urandom)); br_q.push_back(0);
            exp_q.push_back(W_RW | W_DONE); rdy_q.push_back(1'($urandom)); br_q.push_back(0);
        end else if (op == 7'b1100011) begin
            exp_q.push_back(W_SRCA | W_SUB | W_PCS | W_DONE); rdy_q.push_back(1'($urandom)); br_q.push_back(1);
        end

        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            reset     = 1'b0;
            opcode    = op;
            mem_ready = rdy_q[i];
            zero      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            e = exp_q[i];
            if (br_q[i] && zero) e = e | W_PCW;
            check(tag, 32'(ctl_word()), 32'(e));
            check("excl", 32'({MemRead & MemWrite, RegWrite & MemWrite}), 32'd0);
        end
    endtask

    logic [6:0] legal_ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

    initial begin
        logic [6:0] op;
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0;

        do_reset(2);
        run_instr(7'b0110011, 0, 0, 2, "r_type");
`ifdef MC_PERF_CNT_EN
        run_instr(7'b0110011, 0, 0, 2, "r_type");
        run_instr(7'b0110011, 0, 0, 2, "r_type");
        @(negedge clk);
        #1;
        check("cycle_cnt", cycle_cnt, 32'd12);
        check("instr_cnt", instr_cnt, 32'd3);
`endif
        run_instr(7'b0000011, 0, 3, 2, "lw_stall");
        run_instr(7'b1100011, 0, 0, 1, "beq_taken");
        run_instr(7'b1100011, 0, 0, 0, "beq_not");
        run_instr(7'b0100011, 0, 0, 2, "sw");
        run_instr(7'b1111111, 0, 0, 2, "illegal");
        run_instr(7'b0010011, 2, 0, 2, "i_alu_fstall");

        // Reset while waiting in the load's memory-read state.
        run_instr(7'b0000011, 0, 0, 2, "pre_abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b0; opcode = 7'b0000011; mem_ready = (i == 0); zero = 1'b0;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("abort_in_mem_rd", 32'(ctl_word()), 32'(W_MRD | W_IORD));
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("abort_reset_cycle", 32'(ctl_word()), 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        check("abort_then_fetch", 32'(ctl_word()), 32'(W_MRD | W_B4));
        run_instr(7'b0110011, 0, 0, 2, "after_abort");

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do begin
                    op = 7'($urandom);
                end while (op inside {7'b0110011, 7'b0010011, 7'b0000011,
                                      7'b0100011, 7'b1100011});
            end else begin
                op = legal_ops[$urandom_range(0, 4)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 2, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
